pipe_stage_reg: RTL and testbench

- Generic, parametrised inter-stage pipeline register for the mips32 core. It generalises the fixed EX/MEM latch so every stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB) can use one block.
- Carries a flat payload bus plus a valid bit, and applies the core's stall-vector and flush rules.
- Circulates multi-cycle side state (e.g. hilo/cnt of madd/msub/div) while the stage is stalled.
- Adds hold-cycle instrumentation and a bubble-insert indication that the fixed latch lacks.

---
 rtl/pipe_stage_reg_pkg.sv | 23 ++
 rtl/pipe_stage_reg_if.sv | 17 +
 rtl/pipe_stage_reg_sat_counter.sv | 17 +
 rtl/pipe_stage_reg.sv | 57 +++++
 tb/tb_pipe_stage_reg.sv | 125 ++++++++++++
 5 files changed

// File: rtl/pipe_stage_reg_pkg.sv
// pipe_stage_reg_pkg: shared stall-vector indices, stop encodings and per-boundary payload layout.
package pipe_stage_reg_pkg;
  localparam int STG_PC  = 0;
  localparam int STG_IF  = 1;
  localparam int STG_ID  = 2;
  localparam int STG_EX  = 3;
  localparam int STG_MEM = 4;
  localparam int STG_WB  = 5;
  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;
  localparam int IF_ID_W  = 64;
  localparam int ID_EX_W  = 128;
  localparam int EX_MEM_W = 128;
  localparam int MEM_WB_W = 72;
  localparam int HILO_CNT_W = 66;
  // EX/MEM payload field offsets (LSB positions) for the stage wrappers
  localparam int EXM_WDATA_OFF = 0;
  localparam int EXM_WADDR_OFF = 32;
  localparam int EXM_WREG_OFF  = 37;
  localparam int EXM_ALUOP_OFF = 38;
  localparam int EXM_MADDR_OFF = 46;
  localparam int EXM_RS2_OFF   = 78;
endpackage

// File: rtl/pipe_stage_reg_if.sv
// pipe_stage_reg_if: upstream payload/side-state inputs and registered stage outputs.
interface pipe_stage_reg_if #(
  parameter int DATA_W  = pipe_stage_reg_pkg::EX_MEM_W,
  parameter int CARRY_W = pipe_stage_reg_pkg::HILO_CNT_W,
  parameter int CNT_W   = 8
);
  logic               in_valid;
  logic [DATA_W-1:0]  in_data;
  logic [CARRY_W-1:0] carry_i;
  logic               out_valid;
  logic [DATA_W-1:0]  out_data;
  logic [CARRY_W-1:0] carry_o;
  logic [CNT_W-1:0]   hold_cycles;
  logic               bubble_o;
  modport master (output in_valid, in_data, carry_i, input out_valid, out_data, carry_o, hold_cycles, bubble_o);
  modport slave  (input in_valid, in_data, carry_i, output out_valid, out_data, carry_o, hold_cycles, bubble_o);
endinterface

// File: rtl/pipe_stage_reg_sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear and async active-low reset.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr_i ? '0 : (inc_i && cnt_q != '1) ? cnt_q + W'(1) : cnt_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt_o = cnt_q;
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic inter-stage pipeline latch with stall/flush rules and multi-cycle side-state feedback.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int                DATA_W   = 128,
  parameter int                CARRY_W  = 66,
  parameter int                STALL_W  = 6,
  parameter int                STAGE    = STG_EX,
  parameter logic [DATA_W-1:0] NOP_DATA = '0,
  parameter int                CNT_W    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  pipe_stage_reg_if.slave    bus
);
  // the last boundary has no downstream stall bit, so dn reads as NoStop
  localparam bit HAS_DN = STAGE < STALL_W - 1;
  localparam int DN_IDX = HAS_DN ? STAGE + 1 : STAGE;
  logic               up, dn, hold;
  logic               valid_q, valid_d, bubble_q, bubble_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [CARRY_W-1:0] carry_q, carry_d;
  always_comb begin
    up       = stall[STAGE] == STOP;
    dn       = HAS_DN && stall[DN_IDX] == STOP;
    hold     = !flush && up && dn;
    valid_d  = hold ? valid_q : (flush || up) ? 1'b0 : bus.in_valid;
    data_d   = hold ? data_q : (flush || up) ? NOP_DATA : bus.in_data;
    carry_d  = (!flush && up) ? bus.carry_i : '0;
    bubble_d = !flush && up && !dn;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      valid_q  <= 1'b0;
      data_q   <= NOP_DATA;
      carry_q  <= '0;
      bubble_q <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      data_q   <= data_d;
      carry_q  <= carry_d;
      bubble_q <= bubble_d;
    end
  sat_counter #(.W(CNT_W)) u_hold (
    .clk   (clk),
    .rst   (rst),
    .clr_i (!hold),
    .inc_i (hold),
    .cnt_o (bus.hold_cycles)
  );
  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.carry_o   = carry_q;
  assign bus.bubble_o  = bubble_q;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed checks of reset, advance, bubble, hold saturation, flush and top boundary.
module tb_pipe_stage_reg;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       flush = 1'b0;
  logic [5:0] stall = '0;
  logic [5:0] stall_t = '0;
  int         n_chk = 0;
  int         n_pass = 0;
  localparam logic [127:0] A5 = {16{8'hA5}};
  localparam logic [65:0]  CDEAD = 66'h2_DEADBEEF_CAFEF00D;
  pipe_stage_reg_if #(.DATA_W(128), .CARRY_W(66), .CNT_W(8)) b_if ();
  pipe_stage_reg_if #(.DATA_W(128), .CARRY_W(66), .CNT_W(8)) t_if ();
  pipe_stage_reg #(.STAGE(3)) dut (.clk(clk), .rst(rst), .stall(stall), .flush(flush), .bus(b_if));
  pipe_stage_reg #(.STAGE(5)) dut_top (.clk(clk), .rst(rst), .stall(stall_t), .flush(flush), .bus(t_if));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic drive(input logic [5:0] s, input logic v, input logic [127:0] d, input logic [65:0] c);
    stall = s;
    b_if.in_valid = v;
    b_if.in_data = d;
    b_if.carry_i = c;
  endtask
  initial begin
    drive(6'h00, 1'b1, 128'h99, 66'h7);
    t_if.in_valid = 1'b0;
    t_if.in_data = '0;
    t_if.carry_i = '0;
    #3;
    check("rst_valid", 128'(b_if.out_valid), 128'd0);
    check("rst_data", b_if.out_data, 128'd0);
    check("rst_carry", 128'(b_if.carry_o), 128'd0);
    check("rst_hold", 128'(b_if.hold_cycles), 128'd0);
    check("rst_bubble", 128'(b_if.bubble_o), 128'd0);
    @(negedge clk);
    rst = 1'b1;
    drive(6'h00, 1'b1, A5, 66'h7);
    t_if.in_valid = 1'b1;
    t_if.in_data = 128'h55;
    step();
    check("adv_valid", 128'(b_if.out_valid), 128'd1);
    check("adv_data", b_if.out_data, A5);
    check("adv_carry", 128'(b_if.carry_o), 128'd0);
    check("top_adv_data", t_if.out_data, 128'h55);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("midrst_valid", 128'(b_if.out_valid), 128'd0);
    check("midrst_data", b_if.out_data, 128'd0);
    @(negedge clk);
    rst = 1'b1;
    drive(6'h00, 1'b1, A5, '0);
    step();
    check("reload_data", b_if.out_data, A5);
    drive(6'b001111, 1'b1, 128'h1234, CDEAD);
    step();
    check("bub_valid", 128'(b_if.out_valid), 128'd0);
    check("bub_data", b_if.out_data, 128'd0);
    check("bub_carry", 128'(b_if.carry_o), 128'(CDEAD));
    check("bub_pulse", 128'(b_if.bubble_o), 128'd1);
    check("bub_hold", 128'(b_if.hold_cycles), 128'd0);
    drive(6'h00, 1'b1, 128'h1234, CDEAD);
    step();
    check("bub_end", 128'(b_if.bubble_o), 128'd0);
    check("load_1234", b_if.out_data, 128'h1234);
    check("load_carry0", 128'(b_if.carry_o), 128'd0);
    drive(6'b011111, 1'b0, 128'hFFFF, 66'h5);
    for (int i = 1; i <= 300; i++) begin
      step();
      if (i == 1 || i == 254 || i == 255 || i == 256 || i == 300)
        check($sformatf("hold_cnt_%0d", i), 128'(b_if.hold_cycles), (i > 255) ? 128'd255 : 128'(i));
    end
    check("hold_data", b_if.out_data, 128'h1234);
    check("hold_valid", 128'(b_if.out_valid), 128'd1);
    check("hold_carry", 128'(b_if.carry_o), 128'd5);
    check("hold_nobubble", 128'(b_if.bubble_o), 128'd0);
    drive(6'h00, 1'b0, 128'hBEEF, 66'h5);
    step();
    check("rel_hold", 128'(b_if.hold_cycles), 128'd0);
    check("rel_valid", 128'(b_if.out_valid), 128'd0);
    check("rel_data_verbatim", b_if.out_data, 128'hBEEF);
    drive(6'h00, 1'b1, 128'h77, '0);
    step();
    drive(6'b011111, 1'b1, 128'h88, 66'h3);
    step();
    step();
    step();
    check("pre_flush_hold", 128'(b_if.hold_cycles), 128'd3);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("fl_valid", 128'(b_if.out_valid), 128'd0);
    check("fl_data", b_if.out_data, 128'd0);
    check("fl_carry", 128'(b_if.carry_o), 128'd0);
    check("fl_hold", 128'(b_if.hold_cycles), 128'd0);
    check("fl_bubble", 128'(b_if.bubble_o), 128'd0);
    drive(6'b001111, 1'b1, 128'hC0FFEE, 66'h1);
    step();
    check("cc_carry1", 128'(b_if.carry_o), 128'd1);
    drive(6'b001111, 1'b1, 128'hC0FFEE, 66'h2);
    step();
    check("cc_carry2", 128'(b_if.carry_o), 128'd2);
    drive(6'h00, 1'b1, 128'hC0FFEE, 66'h3);
    step();
    check("cc_carry0", 128'(b_if.carry_o), 128'd0);
    check("cc_data", b_if.out_data, 128'hC0FFEE);
    stall_t = 6'b100000;
    t_if.carry_i = 66'h3;
    step();
    check("top_bubble", 128'(t_if.bubble_o), 128'd1);
    check("top_valid", 128'(t_if.out_valid), 128'd0);
    check("top_carry", 128'(t_if.carry_o), 128'd3);
    check("top_hold", 128'(t_if.hold_cycles), 128'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
